ras_return_checker: RTL and testbench
=====================================

Name: ras_return_checker

Overview:
- Resolution end of the return-address prediction path.
- Fetch/decode issues predicted return targets; the checker holds them in an in-order queue.
- When execute computes the real jalr target, the checker compares it against the oldest outstanding prediction.
- It reports hit or mispredict with the corrected target, kills wrong-path predictions, and keeps hit/miss statistics.

Parameters:
- XLEN, 64, width of addresses.
- DEPTH, 4, maximum outstanding predictions (power of two, >=2).
- CNT_W, 32, width of the hit/miss statistic counters.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  synchronous reset, active-high.
- pred_valid_in  input  1  a predicted return was issued this cycle.
- pred_target_in  input  XLEN  predicted return target.
- pred_ready_out  output  1  queue can accept a prediction this cycle (combinational: not full, or a pop is occurring this cycle).
- resolve_valid_in  input  1  execute resolved the oldest predicted return this cycle.
- resolve_target_in  input  XLEN  actual computed target.
- flush_in  input  1  external pipeline flush (interrupt, older branch mispredict).
- match_out  output  1  registered pulse: last resolve matched.
- mispredict_out  output  1  registered pulse: last resolve did not match.
- correct_target_out  output  XLEN  target to redirect fetch to; valid while mispredict_out=1.
- pending_count_out  output  $clog2(DEPTH+1)  number of queued predictions.
- hit_count_out  output  CNT_W  saturating count of matches.
- miss_count_out  output  CNT_W  saturating count of mispredicts.
- overflow_out  output  1  sticky: prediction offered while the queue could not accept it.
- underflow_out  output  1  sticky: resolve arrived with an empty queue.

Behaviour:
- Reset (rst_in=1 at an edge): queue empty, pointers 0, pending_count_out=0, all pulses 0, correct_target_out=0, counters 0, sticky flags 0. Reset dominates every other input in the same cycle.
- Queue: circular FIFO of DEPTH entries with read and write pointers that wrap modulo DEPTH. Count is held separately, so full (count=DEPTH) and empty (count=0) are unambiguous.
- Push: pred_valid_in & pred_ready_out writes pred_target_in at the write pointer and increments the write pointer.
- Refused push: pred_valid_in & ~pred_ready_out drops the prediction and sets overflow_out.
- Pop/compare: resolve_valid_in & (count!=0) compares resolve_target_in with the head entry, full XLEN equality. Next cycle exactly one of match_out and mispredict_out is 1, for one cycle only. Latency is 1 cycle.
- Match: pop the head and increment hit_count_out unless saturated at all-ones.
- Mispredict:
  - increment miss_count_out (saturating);
  - register correct_target_out <= resolve_target_in;
  - clear the whole queue (all younger predictions are wrong-path), setting count=0 and both pointers equal;
  - discard any push in the same cycle.
- Simultaneous push and matching pop: both take effect and count is unchanged. This is allowed when full, since the pop frees the slot.
- Resolve on empty queue: no compare, no pulses, counters unchanged, underflow_out set. A push in the same cycle proceeds.
- flush_in=1: queue cleared and pushes/resolves in that cycle ignored. match_out and mispredict_out are 0 next cycle; correct_target_out holds its value. Counters and sticky flags are unchanged.
- correct_target_out holds its value until the next mispredict or reset.
- Outputs never carry X after reset; unused queue entries may hold stale data.

Test Plan:
- Reset then 3 pushes (0x1000, 0x2000, 0x3000), then resolve 0x1000 -> next cycle match_out=1, mispredict_out=0, pending=2, hit_count_out=1.
- With pending={0x2000,0x3000}, resolve 0x2004 plus push 0x4000 in the same cycle -> next cycle mispredict_out=1, correct_target_out=0x2004, pending=0, miss_count_out=1, push discarded.
- Fill DEPTH=4 entries, then push 0x5000 alone -> pred_ready_out=0, overflow_out=1, pending stays 4. Next, push 0x6000 with a matching resolve -> pending stays 4, and the new tail equals 0x6000 when popped last.
- Resolve with an empty queue -> no pulse, underflow_out=1, counters unchanged.
- 2 queued entries, flush_in=1 together with a matching resolve -> next cycle no pulses, pending=0, hit_count_out unchanged.
- Preload the counters to all-ones via 2^CNT_W matches (use CNT_W=4: 16 matches) -> hit_count_out stays 15. Then reset mid-stream with 2 pending -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ras_return_checker.sv
// Return-address prediction checker: queues predicted return targets in order and
// resolves each against the real jalr target, reporting hit/mispredict and statistics.
module ras_return_checker #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         pred_valid_in,
    input  logic [XLEN-1:0]              pred_target_in,
    output logic                         pred_ready_out,
    input  logic                         resolve_valid_in,
    input  logic [XLEN-1:0]              resolve_target_in,
    input  logic                         flush_in,
    output logic                         match_out,
    output logic                         mispredict_out,
    output logic [XLEN-1:0]              correct_target_out,
    output logic [$clog2(DEPTH+1)-1:0]   pending_count_out,
    output logic [CNT_W-1:0]             hit_count_out,
    output logic [CNT_W-1:0]             miss_count_out,
    output logic                         overflow_out,
    output logic                         underflow_out
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            pop_req;
    logic            head_hit;
    logic            push_ok;

    always_comb begin
        pop_req        = resolve_valid_in && (count != '0);
        head_hit       = (mem[rd_ptr] == resolve_target_in);
        pred_ready_out = (count != CW'(DEPTH)) || pop_req;
        // A mispredict squashes the same-cycle push along with the rest of the wrong path.
        push_ok        = pred_valid_in && pred_ready_out && !flush_in && !(pop_req && !head_hit);
    end

    assign pending_count_out = count;

    always_ff @(posedge clk_in) begin
        if (push_ok && !rst_in) begin
            mem[wr_ptr] <= pred_target_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_ptr             <= '0;
            wr_ptr             <= '0;
            count              <= '0;
            match_out          <= 1'b0;
            mispredict_out     <= 1'b0;
            correct_target_out <= '0;
            hit_count_out      <= '0;
            miss_count_out     <= '0;
            overflow_out       <= 1'b0;
            underflow_out      <= 1'b0;
        end else begin
            match_out      <= 1'b0;
            mispredict_out <= 1'b0;
            if (flush_in) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (pred_valid_in && !pred_ready_out) begin
                    overflow_out <= 1'b1;
                end
                if (resolve_valid_in && (count == '0)) begin
                    underflow_out <= 1'b1;
                end
                if (pop_req && !head_hit) begin
                    mispredict_out     <= 1'b1;
                    correct_target_out <= resolve_target_in;
                    if (miss_count_out != '1) begin
                        miss_count_out <= miss_count_out + CNT_W'(1);
                    end
                    rd_ptr <= '0;
                    wr_ptr <= '0;
                    count  <= '0;
                end else begin
                    if (pop_req) begin
                        match_out <= 1'b1;
                        rd_ptr    <= rd_ptr + PW'(1);
                        if (hit_count_out != '1) begin
                            hit_count_out <= hit_count_out + CNT_W'(1);
                        end
                    end
                    if (push_ok) begin
                        wr_ptr <= wr_ptr + PW'(1);
                    end
                    count <= count + CW'(push_ok) - CW'(pop_req);
                end
            end
        end
    end

endmodule

// File: tb/tb_ras_return_checker.sv
// Directed bench for ras_return_checker: expectations are queued when a step is driven
// and popped/compared after the clock edge that produces the DUT response.
module tb_ras_return_checker;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 4;

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b0;
    logic             pred_valid_in = 1'b0;
    logic [XLEN-1:0]  pred_target_in = '0;
    logic             pred_ready_out;
    logic             resolve_valid_in = 1'b0;
    logic [XLEN-1:0]  resolve_target_in = '0;
    logic             flush_in = 1'b0;
    logic             match_out;
    logic             mispredict_out;
    logic [XLEN-1:0]  correct_target_out;
    logic [2:0]       pending_count_out;
    logic [CNT_W-1:0] hit_count_out;
    logic [CNT_W-1:0] miss_count_out;
    logic             overflow_out;
    logic             underflow_out;

    ras_return_checker #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .pred_valid_in      (pred_valid_in),
        .pred_target_in     (pred_target_in),
        .pred_ready_out     (pred_ready_out),
        .resolve_valid_in   (resolve_valid_in),
        .resolve_target_in  (resolve_target_in),
        .flush_in           (flush_in),
        .match_out          (match_out),
        .mispredict_out     (mispredict_out),
        .correct_target_out (correct_target_out),
        .pending_count_out  (pending_count_out),
        .hit_count_out      (hit_count_out),
        .miss_count_out     (miss_count_out),
        .overflow_out       (overflow_out),
        .underflow_out      (underflow_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        string            tag;
        logic             match;
        logic             mis;
        logic [XLEN-1:0]  ct;
        logic [2:0]       pend;
        logic [CNT_W-1:0] hit;
        logic [CNT_W-1:0] miss;
        logic             ovf;
        logic             unf;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;

    // Running expected state that persists between steps.
    logic [XLEN-1:0]  e_ct   = '0;
    logic [CNT_W-1:0] e_hit  = '0;
    logic [CNT_W-1:0] e_miss = '0;
    logic             e_ovf  = 1'b0;
    logic             e_unf  = 1'b0;

    task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [XLEN-1:0] pt, input logic rv,
                         input logic [XLEN-1:0] rt, input logic fl, input logic rs);
        @(negedge clk_in);
        pred_valid_in     = pv;
        pred_target_in    = pt;
        resolve_valid_in  = rv;
        resolve_target_in = rt;
        flush_in          = fl;
        rst_in            = rs;
    endtask

    task automatic expect_push(input string tag, input logic m, input logic mp, input logic [2:0] pend);
        exp_t e;
        e.tag = tag; e.match = m; e.mis = mp; e.ct = e_ct; e.pend = pend;
        e.hit = e_hit; e.miss = e_miss; e.ovf = e_ovf; e.unf = e_unf;
        sb.push_back(e);
    endtask

    task automatic collect();
        exp_t e;
        @(posedge clk_in);
        #1;
        if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL scoreboard: observed empty queue expected one entry");
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".match"},   XLEN'(match_out),          XLEN'(e.match));
        chk({e.tag, ".mispred"}, XLEN'(mispredict_out),     XLEN'(e.mis));
        chk({e.tag, ".ctarget"}, correct_target_out,        e.ct);
        chk({e.tag, ".pending"}, XLEN'(pending_count_out),  XLEN'(e.pend));
        chk({e.tag, ".hits"},    XLEN'(hit_count_out),      XLEN'(e.hit));
        chk({e.tag, ".misses"},  XLEN'(miss_count_out),     XLEN'(e.miss));
        chk({e.tag, ".ovf"},     XLEN'(overflow_out),       XLEN'(e.ovf));
        chk({e.tag, ".unf"},     XLEN'(underflow_out),      XLEN'(e.unf));
    endtask

    task automatic step(input string tag, input logic pv, input logic [XLEN-1:0] pt,
                        input logic rv, input logic [XLEN-1:0] rt, input logic fl, input logic rs,
                        input logic m, input logic mp, input logic [2:0] pend);
        drive(pv, pt, rv, rt, fl, rs);
        expect_push(tag, m, mp, pend);
        collect();
    endtask

    initial begin
        // Reset
        step("reset", 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);

        // Three pushes then a matching resolve
        step("push1", 1'b1, 64'h1000, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        step("push2", 1'b1, 64'h2000, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
        step("push3", 1'b1, 64'h3000, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
        e_hit = 4'd1;
        step("hit1", 1'b0, '0, 1'b1, 64'h1000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2);

        // Mispredict with a same-cycle push that must be discarded
        e_miss = 4'd1; e_ct = 64'h2004;
        step("mispred", 1'b1, 64'h4000, 1'b1, 64'h2004, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);

        // Fill, then a refused push
        step("fill1", 1'b1, 64'h10, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        step("fill2", 1'b1, 64'h20, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
        step("fill3", 1'b1, 64'h30, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3);
        step("fill4", 1'b1, 64'h40, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4);
        drive(1'b1, 64'h5000, 1'b0, '0, 1'b0, 1'b0);
        #1 chk("full.ready", XLEN'(pred_ready_out), XLEN'(0));
        e_ovf = 1'b1;
        expect_push("overflow", 1'b0, 1'b0, 3'd4);
        collect();

        // Push and matching pop while full
        drive(1'b1, 64'h6000, 1'b1, 64'h10, 1'b0, 1'b0);
        #1 chk("fullpop.ready", XLEN'(pred_ready_out), XLEN'(1));
        e_hit = 4'd2;
        expect_push("fullpop", 1'b1, 1'b0, 3'd4);
        collect();
        e_hit = 4'd3; step("drain20",   1'b0, '0, 1'b1, 64'h20,   1'b0, 1'b0, 1'b1, 1'b0, 3'd3);
        e_hit = 4'd4; step("drain30",   1'b0, '0, 1'b1, 64'h30,   1'b0, 1'b0, 1'b1, 1'b0, 3'd2);
        e_hit = 4'd5; step("drain40",   1'b0, '0, 1'b1, 64'h40,   1'b0, 1'b0, 1'b1, 1'b0, 3'd1);
        e_hit = 4'd6; step("drain6000", 1'b0, '0, 1'b1, 64'h6000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);

        // Resolve on an empty queue
        e_unf = 1'b1;
        step("underflow", 1'b0, '0, 1'b1, 64'h7, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

        // Flush together with a matching resolve
        step("pushA", 1'b1, 64'hA, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        step("pushB", 1'b1, 64'hB, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
        step("flush", 1'b1, 64'hE, 1'b1, 64'hA, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        step("pushC", 1'b1, 64'hC, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        e_hit = 4'd7;
        step("hitC", 1'b0, '0, 1'b1, 64'hC, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);

        // Drive the hit counter into saturation
        for (int i = 0; i < 10; i++) begin
            step("satpush", 1'b1, 64'h100 + XLEN'(i), 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
            if (e_hit != '1) e_hit = e_hit + 4'd1;
            step("sathit", 1'b0, '0, 1'b1, 64'h100 + XLEN'(i), 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        end
        chk("sat.final", XLEN'(hit_count_out), XLEN'(15));

        // Reset with entries pending
        step("pendP", 1'b1, 64'hD0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        step("pendQ", 1'b1, 64'hD8, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2);
        e_ct = '0; e_hit = '0; e_miss = '0; e_ovf = 1'b0; e_unf = 1'b0;
        step("midreset", 1'b1, 64'hDD, 1'b1, 64'hD0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        #1 chk("postreset.ready", XLEN'(pred_ready_out), XLEN'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
